// File: rtl/result_uart_reporter.sv
// result_uart_reporter
//   Captures each SUBLEQ result strobe into a small FIFO. Each result is sent
//   over a UART TX pin as DATA_W/4 uppercase hex characters, then CR and LF.
//   The default frame format is 8N1, LSB first.
//   Define RESULT_UART_PARITY_EN to add an even-parity bit to every frame
//   (8E1). The parity bit goes between the data bits and the stop bit.
//   Parameter limits: CLKS_PER_BIT >= 2; FIFO_DEPTH is a power of two and
//   >= 2; DATA_W is a multiple of 4.
module result_uart_reporter #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4,
    parameter int DATA_W       = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clk_enable,
    input  logic                         result_ld,
    input  logic [DATA_W-1:0]            result_in,
    output logic                         uart_tx,
    output logic                         busy,
    output logic                         overflow,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int NIBBLES   = DATA_W / 4;
    localparam int NUM_CHARS = NIBBLES + 2;
    localparam int CHAR_W    = $clog2(NUM_CHARS);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int BAUD_W    = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CHAR_W-1:0] CHAR_CR   = CHAR_W'(NIBBLES);
    localparam logic [CHAR_W-1:0] CHAR_LAST = CHAR_W'(NUM_CHARS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef RESULT_UART_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    // ---------------------------------------------------------------- capture
    logic capture_pend_q, capture_pend_d;

    // ------------------------------------------------------------------- fifo
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              full;
    logic              push_ok;
    logic              pop;

    // -------------------------------------------------------------------- fsm
    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [CHAR_W-1:0] char_idx_q, char_idx_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [3:0]        nibble;
    logic [7:0]        cur_char;
    logic              baud_done;
    logic              tx;

    // Capture is delayed one cycle, so result_in already holds the new result.
    assign capture_pend_d = clk_enable && result_ld;

    // Occupancy, pointer and overflow update. A push into a full FIFO still
    // succeeds when a pop happens in the same cycle.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so this block cannot infer a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        full       = (count_q == CNT_FULL);
        push_ok    = capture_pend_q && (!full || pop);

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (capture_pend_q && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    // Maps the current character index to the ASCII byte being sent.
    always_comb begin
        nibble = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (char_idx_q == CHAR_W'(i)) begin
                nibble = word_q[DATA_W-1-4*i -: 4];
            end
        end
        if (char_idx_q == CHAR_CR) begin
            cur_char = 8'h0D;
        end else if (char_idx_q == CHAR_LAST) begin
            cur_char = 8'h0A;
        end else if (nibble < 4'd10) begin
            cur_char = 8'h30 + {4'h0, nibble};
        end else begin
            cur_char = 8'h37 + {4'h0, nibble};
        end
    end

    // Next-state and TX-level logic for the serializer.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        char_idx_d = char_idx_q;
        word_d     = word_q;
        pop        = 1'b0;
        tx         = 1'b1;
        baud_done  = (baud_cnt_q == BAUD_LAST);

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop        = 1'b1;
                    word_d     = mem_q[rd_ptr_q];
                    char_idx_d = '0;
                    baud_cnt_d = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                tx = 1'b0;
                if (baud_done) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                tx = cur_char[bit_idx_q];
                if (baud_done) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef RESULT_UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
`ifdef RESULT_UART_PARITY_EN
            S_PARITY: begin
                tx = ^cur_char;
                if (baud_done) begin
                    baud_cnt_d = '0;
                    state_d    = S_STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
`endif
            S_STOP: begin
                tx = 1'b1;
                if (baud_done) begin
                    baud_cnt_d = '0;
                    if (char_idx_q == CHAR_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        char_idx_d = char_idx_q + CHAR_W'(1);
                        state_d    = S_START;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers. Reset aborts any frame and discards queued results.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
        if (!rst_n) begin
            capture_pend_q <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            overflow_q     <= 1'b0;
            state_q        <= S_IDLE;
            baud_cnt_q     <= '0;
            bit_idx_q      <= '0;
            char_idx_q     <= '0;
            word_q         <= '0;
        end else begin
            capture_pend_q <= capture_pend_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            overflow_q     <= overflow_d;
            state_q        <= state_d;
            baud_cnt_q     <= baud_cnt_d;
            bit_idx_q      <= bit_idx_d;
            char_idx_q     <= char_idx_d;
            word_q         <= word_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset. Only valid entries are ever read, and the pointers do get reset.
        if (push_ok) begin
            mem_q[wr_ptr_q] <= result_in;
        end
    end

    // uart_tx comes straight from registered state, so reset forces the line high at once.
    assign uart_tx    = tx;
    assign busy       = (state_q != S_IDLE) || (count_q != '0);
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_result_uart_reporter.sv
// Directed bench for result_uart_reporter (CLKS_PER_BIT=4, FIFO_DEPTH=4, DATA_W=64).
// A cycle-sampled UART receiver decodes the TX line. It checks that every bit
// is held for the full bit period.
module tb_result_uart_reporter;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int DW    = 64;
`ifdef RESULT_UART_PARITY_EN
    localparam int FB    = 11;
`else
    localparam int FB    = 10;
`endif
    localparam int FRAME = FB * CPB;
    localparam int LINE  = 18 * FRAME;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clk_enable = 1'b1;
    logic          result_ld = 1'b0;
    logic [DW-1:0] result_in = '0;
    logic          uart_tx;
    logic          busy;
    logic          overflow;
    logic [2:0]    fifo_count;

    int checks = 0;
    int failures = 0;

    logic [7:0] rx_bytes[$];
    int         rx_start[$];
    logic       rx_par[$];
    int         glitches = 0;
    int         par_err = 0;
    int         cyc = 0;

    always #5 clk = ~clk;

    result_uart_reporter #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .DATA_W      (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_enable(clk_enable),
        .result_ld (result_ld),
        .result_in (result_in),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .overflow  (overflow),
        .fifo_count(fifo_count)
    );

    // Receiver: takes one sample per cycle on the falling edge and decodes each frame.
    initial begin
        logic [FRAME-1:0] samp;
        logic [7:0]       data;
        int               cnt;
        int               st;
        bit               rx_on;
        rx_on = 1'b0;
        cnt = 0;
        st = 0;
        samp = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                rx_on = 1'b0;
            end else if (!rx_on) begin
                if (uart_tx === 1'b0) begin
                    rx_on = 1'b1;
                    cnt = 0;
                    samp = '0;
                    st = cyc;
                end
            end else begin
                cnt++;
                samp[cnt] = uart_tx;
                if (cnt == FRAME - 1) begin
                    for (int k = 0; k < FB; k++)
                        for (int j = 1; j < CPB; j++)
                            if (samp[k*CPB+j] !== samp[k*CPB]) glitches++;
                    if (samp[(FB-1)*CPB] !== 1'b1) glitches++;
                    for (int i = 0; i < 8; i++) data[i] = samp[(i+1)*CPB];
`ifdef RESULT_UART_PARITY_EN
                    if (samp[9*CPB] !== ^data) par_err++;
                    rx_par.push_back(samp[9*CPB]);
`endif
                    rx_bytes.push_back(data);
                    rx_start.push_back(st);
                    rx_on = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_line(input string tag, input int idx, input logic [63:0] v);
        logic [7:0] exp;
        logic [3:0] n;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                n = v[63-4*i -: 4];
                exp = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
            end else begin
                exp = (i == 16) ? 8'h0D : 8'h0A;
            end
            check($sformatf("%s_char%0d", tag, i), rx_bytes[idx+i], exp);
        end
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin
            step(1);
            n++;
        end
        check({tag, "_idle_timeout"}, busy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Sends one strobe, then checks the push latency, the first start bit and the line length.
    task automatic run_single(input string tag, input logic [63:0] v, output int base);
        base = rx_bytes.size();
        @(negedge clk);
        result_ld = 1'b1;
        @(negedge clk);
        result_in = v;
        result_ld = 1'b0;
        check({tag, "_cnt_after_strobe"}, fifo_count, 3'd0);
        step(1);
        check({tag, "_cnt_push_lat2"}, fifo_count, 3'd1);
        step(1);
        check({tag, "_first_start_low"}, uart_tx, 1'b0);
        check({tag, "_cnt_after_pop"}, fifo_count, 3'd0);
        check({tag, "_busy_tx"}, busy, 1'b1);
        step(LINE - 1);
        check({tag, "_busy_last_cycle"}, busy, 1'b1);
        step(1);
        check({tag, "_busy_done"}, busy, 1'b0);
        check({tag, "_tx_idle"}, uart_tx, 1'b1);
        check({tag, "_nbytes"}, rx_bytes.size(), base + 18);
        check_line(tag, base, v);
        check({tag, "_line_len"}, rx_start[base+17] + FRAME - rx_start[base], LINE);
    endtask

    initial begin
        int base;
        int nb;

        // Reset, then stay idle.
        step(3);
        rst_n = 1'b1;
        step(100);
        check("idle_tx", uart_tx, 1'b1);
        check("idle_busy", busy, 1'b0);
        check("idle_count", fifo_count, 3'd0);
        check("idle_overflow", overflow, 1'b0);

        // A strobe without clk_enable is ignored.
        clk_enable = 1'b0;
        result_ld = 1'b1;
        step(1);
        result_ld = 1'b0;
        clk_enable = 1'b1;
        step(3);
        check("gated_count", fifo_count, 3'd0);
        check("gated_busy", busy, 1'b0);

        // Single lines.
        run_single("l0123", 64'h0123456789ABCDEF, base);
`ifdef RESULT_UART_PARITY_EN
        check("parity_A", rx_par[base+10], 1'b0);
        check("parity_C", rx_par[base+12], 1'b1);
`endif
        run_single("lfffe", 64'hFFFFFFFFFFFFFFFE, base);
        check("bit_width_glitches", glitches, 0);

        // Six consecutive strobes: five lines, the sixth result is dropped.
        do_reset();
        base = rx_bytes.size();
        result_ld = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            result_in = 64'(k);
        end
        step(1);
        result_in = 64'd6;
        result_ld = 1'b0;
        check("burst_cnt_full", fifo_count, 3'd4);
        check("burst_ovf_pre", overflow, 1'b0);
        step(1);
        check("burst_cnt_drop", fifo_count, 3'd4);
        check("burst_ovf_set", overflow, 1'b1);
        wait_idle("burst", 6 * (LINE + 1));
        check("burst_nbytes", rx_bytes.size(), base + 5 * 18);
        for (int k = 0; k < 5; k++) check_line($sformatf("burst_l%0d", k + 1), base + 18 * k, 64'(k + 1));
        check("burst_gap", rx_start[base+18] - rx_start[base], LINE + 1);
        check("burst_ovf_sticky", overflow, 1'b1);

        // Push into a full FIFO on the same cycle as the IDLE pop.
        do_reset();
        base = rx_bytes.size();
        result_ld = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            result_in = 64'(k);
        end
        step(1);
        result_in = 64'd6;
        result_ld = 1'b0;
        step(LINE - 4);
        result_ld = 1'b1;
        step(1);
        result_in = 64'd7;
        result_ld = 1'b0;
        check("popfull_cnt_pre", fifo_count, 3'd4);
        step(1);
        check("popfull_cnt_same", fifo_count, 3'd4);
        check("popfull_line2_start", uart_tx, 1'b0);
        wait_idle("popfull", 7 * (LINE + 1));
        check("popfull_nbytes", rx_bytes.size(), base + 6 * 18);
        check_line("popfull_l2", base + 18, 64'd2);
        check_line("popfull_l6", base + 90, 64'd7);

        // Reset during the fifth character of a line, with a second result still queued.
        do_reset();
        base = rx_bytes.size();
        result_ld = 1'b1;
        step(1);
        result_in = 64'hAAAA_AAAA_AAAA_AAAA;
        step(1);
        result_in = 64'h5555_5555_5555_5555;
        result_ld = 1'b0;
        step(4 * FRAME + 11);
        check("mid_cnt_before", fifo_count, 3'd1);
        check("mid_tx_active", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_tx_high", uart_tx, 1'b1);
        check("rst_count", fifo_count, 3'd0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        nb = rx_bytes.size();
        step(2000);
        check("rst_nbytes_before", nb, base + 4);
        check("rst_no_more_bytes", rx_bytes.size(), nb);
        check("rst_tx_after", uart_tx, 1'b1);
        check("rst_busy_after", busy, 1'b0);
        check("rst_ovf_after", overflow, 1'b0);

        check("all_glitches", glitches, 0);
        check("all_parity", par_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_uart_reporter.md
Name: result_uart_reporter

Overview:
- Sits directly downstream of the SUBLEQ datapath and consumes its result register output and result-load strobe.
- Captures every new ALU result into a small FIFO.
- Streams each captured result as a 16-character ASCII hex line (followed by CR LF) over an 8N1 UART TX pin for board-level observation.
- Decouples the CPU step rate from the slow serial link. Results that arrive while the FIFO is full are dropped and flagged.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 2
- FIFO_DEPTH, 4, result FIFO entries; power of two, >= 2
- DATA_W, 64, result width; must be a multiple of 4

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- clk_enable  input  1  datapath step enable (same signal the datapath uses)
- result_ld  input  1  datapath result-register load enable
- result_in  input  DATA_W  datapath result register output
- uart_tx  output  1  serial TX line, idle high
- busy  output  1  high while the FIFO is non-empty or a line is being transmitted
- overflow  output  1  sticky flag: a result was dropped because the FIFO was full
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port clk, reset port rst_n.
- Reset values:
  - uart_tx=1, busy=0, overflow=0, fifo_count=0
  - FSM in IDLE; all counters 0; FIFO pointers 0.
- Reset mid-frame: the frame is aborted immediately, uart_tx goes high asynchronously, and FIFO contents are discarded.
- Capture:
  - The result register updates on the edge where clk_enable && result_ld.
  - A capture_pend flop is set on that same edge.
  - On the following cycle (capture_pend=1), result_in is pushed, and capture_pend clears.
  - Push latency: 2 cycles from the strobe to fifo_count increment.
- Push/pop rules:
  - Push with the FIFO full and no pop in the same cycle: value dropped, overflow set to 1, and it stays 1 until reset.
  - Push and pop in the same cycle: both take effect and fifo_count is unchanged, including when full (the push is accepted).
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into word_reg, set char_idx=0, go to START. Otherwise stay, with uart_tx=1.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: uart_tx = char[bit_idx], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. Then, if char_idx == DATA_W/4+1, go to IDLE; otherwise increment char_idx and go to START.
- Character map:
  - For char_idx 0..DATA_W/4-1, the character is the nibble word_reg[DATA_W-1-4*char_idx -: 4], most-significant nibble first.
  - Nibbles 0-9 map to 0x30-0x39; nibbles A-F map to 0x41-0x46 (uppercase).
  - char_idx DATA_W/4 sends 0x0D; DATA_W/4+1 sends 0x0A.
- Timing:
  - Line length is (DATA_W/4+2) characters × 10 bits × CLKS_PER_BIT cycles.
  - The first start bit begins 1 cycle after the IDLE pop.
  - Back-to-back lines have exactly 1 idle-high cycle between the final stop bit and the next start bit.
- busy = (state != IDLE) || (fifo_count != 0).
- clk_enable gates only capture. Transmission always runs on clk.

Optional Feature:
- Macro RESULT_UART_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frames become 11 bits, so line length is (DATA_W/4+2) × 11 × CLKS_PER_BIT.
- Undefined: no PARITY state; 8N1 frames exactly as above.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4, DATA_W=64):
- Reset, then idle 100 cycles -> uart_tx=1, busy=0, fifo_count=0, overflow=0.
- One strobe with result_in=64'h0123456789ABCDEF -> fifo_count=1 two cycles after the strobe. The decoded UART bytes are "0123456789ABCDEF" followed by 0x0D 0x0A. The line lasts 720 cycles; busy then returns to 0.
- result_in=64'hFFFFFFFFFFFFFFFE (-2) -> decoded bytes "FFFFFFFFFFFFFFFE\r\n". Each start bit is low for exactly 4 cycles.
- Six strobes 1 cycle apart while the first line is transmitting -> values 1-5 are queued (1 popped immediately, 4 buffered) and value 6 is dropped. overflow=1, and six lines total are NOT produced: exactly five lines are emitted.
- Push into a full FIFO on the same cycle as the IDLE pop -> the push is accepted and fifo_count stays at 4.
- Assert rst_n=0 during the 5th character -> uart_tx=1 in the same cycle, fifo_count=0. After release, no further bytes are emitted. With RESULT_UART_PARITY_EN, the byte 0x41 carries parity bit 0 and 0x43 carries parity bit 1.
